pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameters SHALL be REG_AW (default 5; register-address width), MULDIV_CYCLES (default 4; execute-stage occupancy of a multi-cycle op, minimum 2) and MEM_TIMEOUT (default 255; maximum wait cycles for data memory).
REQ-002 Ports SHALL be:
  - clk, input, 1: the single clock; all state changes on its rising edge.
  - rst_n, input, 1: reset, asynchronous, active-low.
  - Rs1D, Rs2D, input, REG_AW: source registers of the instruction in Decode.
  - Rs1E, Rs2E, RdE, input, REG_AW: source and destination registers in Execute.
  - RdM, RdW, input, REG_AW: destination registers in Memory and Writeback.
  - RegWriteM, RegWriteW, input, 1: register-write enables in Memory and Writeback.
  - LoadE, input, 1: the Execute-stage instruction is a load.
  - PCSrcE, input, 1: branch/jump taken, resolved in Execute.
  - MulDivStartE, input, 1: a multi-cycle op is in Execute.
  - MemReqM, MemReadyM, input, 1: data-memory request and ready.
  - ForwardAE, ForwardBE, output, 2: ALU operand select.
  - StallF, StallD, StallE, StallM, output, 1: hold the pipeline register feeding the named stage.
  - FlushD, FlushE, output, 1: clear the pipeline register feeding D or E; FlushE drives the D/E register flush.
  - BubbleM, BubbleW, output, 1: insert a NOP into M or W.
  - Busy, output, 1: FSM not IDLE.
  - MemErr, output, 1: one-cycle timeout pulse.

Function
REQ-003 Forwarding SHALL be combinational: ForwardAE = 2'b10 if RegWriteM and RdM != 0 and RdM == Rs1E; else 2'b01 if RegWriteW and RdW != 0 and RdW == Rs1E; else 2'b00. ForwardBE SHALL follow the same rule with Rs2E; Memory SHALL take priority over Writeback.
REQ-004 Load-use: lwStall = LoadE and RdE != 0 and (RdE == Rs1D or RdE == Rs2D); it SHALL assert StallF, StallD and FlushE in the same cycle (Mealy).
REQ-005 Branch: PCSrcE SHALL assert FlushD and FlushE in the same cycle, only when the FSM is IDLE and no memory stall is asserted that cycle.
REQ-006 The FSM SHALL have states IDLE, MULDIV and MEMWAIT; Busy = (state != IDLE).
REQ-007 IDLE to MEMWAIT: MemReqM and not MemReadyM. StallF, StallD, StallE, StallM and BubbleW SHALL assert combinationally in that same cycle; the wait counter loads 1.
REQ-008 IDLE to MULDIV: MulDivStartE with no memory-stall condition. StallF, StallD, StallE and BubbleM SHALL assert in that cycle; the op counter loads MULDIV_CYCLES-2.
REQ-009 MEMWAIT: the REQ-007 stalls SHALL hold every cycle. MemReadyM=1 SHALL release the stalls in that cycle and move to IDLE. Otherwise the wait counter increments; reaching MEM_TIMEOUT SHALL pulse MemErr for one cycle, release the stalls and move to IDLE.
REQ-010 MULDIV: the REQ-008 stalls SHALL hold while the counter != 0, with a decrement each cycle. At counter == 0 the stalls SHALL release and the FSM returns to IDLE. Total Execute occupancy SHALL be exactly MULDIV_CYCLES cycles.
REQ-011 Simultaneous MemReqM/!MemReadyM and MulDivStartE in IDLE: MEMWAIT SHALL win (older instruction). MulDivStartE stays held by StallE and SHALL be accepted on the first IDLE cycle after.
REQ-012 FlushE SHALL never assert while StallE is asserted. Any stall condition SHALL override lwStall and branch flushes in the same cycle.
REQ-013 PCSrcE, LoadE and MulDivStartE SHALL be ignored while the FSM is in MULDIV or MEMWAIT. Forwarding SHALL remain active in all states.
REQ-014 Counters SHALL be sized with $clog2 of their maximum and SHALL saturate, never wrapping.

Reset
REQ-015 rst_n low SHALL immediately force state IDLE, both counters to 0 and MemErr to 0, including mid-MULDIV or mid-MEMWAIT.
REQ-016 Under reset, all stall, flush and bubble outputs and Busy SHALL be 0. Forwarding outputs SHALL follow the inputs combinationally.
REQ-017 After release, the first rising edge SHALL evaluate from IDLE.

Structure
REQ-018 Package pipe_ctrl_pkg SHALL hold:
  - the state enum (IDLE, MULDIV, MEMWAIT);
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
REQ-019 Forwarding logic SHALL live in one combinational sub-module, hazard_fwd_unit, instantiated twice (operands A and B). The FSM, counters and stall/flush logic SHALL stay in pipe_hazard_ctrl.

Verification
REQ-020 RegWriteM=1, RdM=5, RegWriteW=1, RdW=5, Rs1E=5, Rs2E=0 -> ForwardAE=2'b10, ForwardBE=2'b00; with RdM=0 -> ForwardAE=2'b01.
REQ-021 LoadE=1, RdE=7, Rs2D=7, FSM IDLE -> StallF=StallD=FlushE=1 for one cycle, StallE=0.
REQ-022 MulDivStartE=1 in IDLE, MULDIV_CYCLES=4 -> StallE high exactly 3 cycles; Busy high 3 cycles; the 4th cycle shows IDLE with stalls low.
REQ-023 MemReqM=1, MemReadyM=0 for 10 cycles, with PCSrcE=1 and MulDivStartE=1 throughout -> StallM high 10 cycles and FlushD=0 throughout; MemReadyM=1 -> stalls drop that cycle, then MULDIV entered.
REQ-024 MEM_TIMEOUT=8, MemReadyM held 0 -> MemErr pulses once, 8 cycles after entry, then IDLE.
REQ-025 rst_n asserted on the 2nd MULDIV cycle -> all stalls and Busy drop asynchronously; after release, a new MulDivStartE yields a full MULDIV_CYCLES occupancy.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// selects and the bundle of stall/flush/bubble controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULDIV  = 2'd1,
    MEMWAIT = 2'd2
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic bubble_m;
    logic bubble_w;
  } hz_ctl_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// One ALU operand's bypass select; Memory beats Writeback, x0 never forwards.
module hazard_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  output logic [1:0]        fwd_o
);

  always_comb begin
    fwd_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_e_i))
      fwd_o = FWD_MEM;
    else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_e_i))
      fwd_o = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use and branch
// handling, plus an FSM that holds the pipe for multi-cycle ops and slow memory.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW        = 5,
  parameter int MULDIV_CYCLES = 4,
  parameter int MEM_TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              LoadE,
  input  logic              PCSrcE,
  input  logic              MulDivStartE,
  input  logic              MemReqM,
  input  logic              MemReadyM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              BubbleM,
  output logic              BubbleW,
  output logic              Busy,
  output logic              MemErr
);

  localparam int OCW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES - 1) : 1;
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OCW-1:0] OC_LOAD = OCW'(MULDIV_CYCLES - 2);
  localparam logic [WCW-1:0] WC_MAX  = WCW'(MEM_TIMEOUT);

  hz_state_e      state_q, state_d;
  logic [OCW-1:0] ocnt_q, ocnt_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           mem_err_q, mem_err_d;
  logic           mem_stall, lw_stall;
  hz_ctl_t        ctl, ctl_o;

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_e_i(Rs1E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(ForwardAE)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_e_i(Rs2E), .rd_m_i(RdM), .rd_w_i(RdW),
    .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .fwd_o(ForwardBE)
  );

  assign mem_stall = MemReqM & ~MemReadyM;
  assign lw_stall  = LoadE & (RdE != '0) & ((RdE == Rs1D) | (RdE == Rs2D));

  always_comb begin
    state_d   = state_q;
    ocnt_d    = ocnt_q;
    wcnt_d    = wcnt_q;
    mem_err_d = 1'b0;
    ctl       = '0;
    unique case (state_q)
      IDLE: begin
        // The memory op is older than the one in Execute, so it wins.
        if (mem_stall) begin
          ctl.stall_f  = 1'b1;
          ctl.stall_d  = 1'b1;
          ctl.stall_e  = 1'b1;
          ctl.stall_m  = 1'b1;
          ctl.bubble_w = 1'b1;
          state_d      = MEMWAIT;
          wcnt_d       = WCW'(1);
        end else if (MulDivStartE) begin
          ctl.stall_f  = 1'b1;
          ctl.stall_d  = 1'b1;
          ctl.stall_e  = 1'b1;
          ctl.bubble_m = 1'b1;
          state_d      = MULDIV;
          ocnt_d       = OC_LOAD;
        end else begin
          ctl.stall_f = lw_stall;
          ctl.stall_d = lw_stall;
          ctl.flush_d = PCSrcE;
          ctl.flush_e = lw_stall | PCSrcE;
        end
      end
      MULDIV: begin
        if (ocnt_q != '0) begin
          ctl.stall_f  = 1'b1;
          ctl.stall_d  = 1'b1;
          ctl.stall_e  = 1'b1;
          ctl.bubble_m = 1'b1;
          ocnt_d       = ocnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      MEMWAIT: begin
        if (MemReadyM) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q >= WC_MAX) begin
          state_d   = IDLE;
          wcnt_d    = '0;
          mem_err_d = 1'b1;
        end else begin
          ctl.stall_f  = 1'b1;
          ctl.stall_d  = 1'b1;
          ctl.stall_e  = 1'b1;
          ctl.stall_m  = 1'b1;
          ctl.bubble_w = 1'b1;
          wcnt_d       = wcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ocnt_q    <= '0;
      wcnt_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ocnt_q    <= ocnt_d;
      wcnt_q    <= wcnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Load-use and branch terms are combinational from inputs, so gate them too.
  assign ctl_o   = rst_n ? ctl : '0;
  assign StallF  = ctl_o.stall_f;
  assign StallD  = ctl_o.stall_d;
  assign StallE  = ctl_o.stall_e;
  assign StallM  = ctl_o.stall_m;
  assign FlushD  = ctl_o.flush_d;
  assign FlushE  = ctl_o.flush_e;
  assign BubbleM = ctl_o.bubble_m;
  assign BubbleW = ctl_o.bubble_w;
  assign Busy    = (state_q != IDLE);
  assign MemErr  = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with a short memory
// timeout shares the inputs for the MemErr scenario.
module tb_pipe_hazard_ctrl;

  localparam int AW = 5;

  logic          clk, rst_n;
  logic [AW-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic          RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE, MemReqM, MemReadyM;

  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleM, BubbleW, Busy, MemErr;
  logic [1:0] t_ForwardAE, t_ForwardBE;
  logic t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE;
  logic t_BubbleM, t_BubbleW, t_Busy, t_MemErr;

  // {SF,SD,SE,SM,FD,FE,BM,BW,BY,ME}
  logic [9:0] v, v8;
  assign v  = {StallF, StallD, StallE, StallM, FlushD, FlushE, BubbleM, BubbleW, Busy, MemErr};
  assign v8 = {t_StallF, t_StallD, t_StallE, t_StallM, t_FlushD, t_FlushE,
               t_BubbleM, t_BubbleW, t_Busy, t_MemErr};

  localparam logic [9:0] C_IDLE = 10'b0000000000;
  localparam logic [9:0] C_LW   = 10'b1100010000;
  localparam logic [9:0] C_BR   = 10'b0000110000;
  localparam logic [9:0] C_BRLW = 10'b1100110000;
  localparam logic [9:0] C_MD0  = 10'b1110001000;
  localparam logic [9:0] C_MDB  = 10'b1110001010;
  localparam logic [9:0] C_BUSY = 10'b0000000010;
  localparam logic [9:0] C_MW0  = 10'b1111000100;
  localparam logic [9:0] C_MWB  = 10'b1111000110;
  localparam logic [9:0] C_ERR  = 10'b0000000001;

  int n_chk = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(.REG_AW(AW), .MULDIV_CYCLES(4), .MEM_TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .BubbleM(BubbleM), .BubbleW(BubbleW),
    .Busy(Busy), .MemErr(MemErr)
  );

  pipe_hazard_ctrl #(.REG_AW(AW), .MULDIV_CYCLES(4), .MEM_TIMEOUT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LoadE(LoadE), .PCSrcE(PCSrcE), .MulDivStartE(MulDivStartE), .MemReqM(MemReqM),
    .MemReadyM(MemReadyM), .ForwardAE(t_ForwardAE), .ForwardBE(t_ForwardBE),
    .StallF(t_StallF), .StallD(t_StallD), .StallE(t_StallE), .StallM(t_StallM),
    .FlushD(t_FlushD), .FlushE(t_FlushE), .BubbleM(t_BubbleM), .BubbleW(t_BubbleW),
    .Busy(t_Busy), .MemErr(t_MemErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0b exp=%0b", tag, act, exp);
    end
  endtask

  // Sample on the falling edge, then move to just after the next rising edge.
  task automatic step(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, {22'b0, v}, {22'b0, exp});
    @(posedge clk); #1;
  endtask

  task automatic step8(input string tag, input logic [9:0] exp);
    @(negedge clk);
    chk(tag, {22'b0, v8}, {22'b0, exp});
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    {RegWriteM, RegWriteW, LoadE, PCSrcE, MulDivStartE, MemReqM, MemReadyM} = '0;

    // Reset: controls low, forwarding still live.
    #12;
    chk("rst_ctl", {22'b0, v}, {22'b0, C_IDLE});
    chk("rst_ctl8", {22'b0, v8}, {22'b0, C_IDLE});
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    #1;
    chk("rst_gated", {22'b0, v}, {22'b0, C_IDLE});
    chk("rst_fwdA", {30'b0, ForwardAE}, 32'd2);
    LoadE = 1'b0; RdE = '0; Rs2D = '0; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RdM = '0; Rs1E = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Forwarding.
    RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd0;
    #1; chk("fwdA_mem", {30'b0, ForwardAE}, 32'd2); chk("fwdB_x0", {30'b0, ForwardBE}, 32'd0);
    RdM = 5'd0;
    #1; chk("fwdA_wb", {30'b0, ForwardAE}, 32'd1);
    RegWriteW = 1'b0;
    #1; chk("fwdA_rf", {30'b0, ForwardAE}, 32'd0);
    RegWriteW = 1'b1; RdM = 5'd9; RegWriteM = 1'b0; Rs2E = 5'd5; Rs1E = 5'd9;
    #1; chk("fwdB_wb", {30'b0, ForwardBE}, 32'd1); chk("fwdA_nowe", {30'b0, ForwardAE}, 32'd0);
    RegWriteM = 1'b1; Rs2E = 5'd9;
    #1; chk("fwdB_mem", {30'b0, ForwardBE}, 32'd2);
    {RegWriteM, RegWriteW} = '0; {Rs1E, Rs2E, RdM, RdW} = '0;

    step("idle", C_IDLE);

    // Load-use and branch.
    LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
    step("lw_rs2", C_LW);
    LoadE = 1'b0;
    step("lw_off", C_IDLE);
    LoadE = 1'b1; Rs2D = 5'd0; Rs1D = 5'd7;
    step("lw_rs1", C_LW);
    RdE = 5'd0; Rs1D = 5'd0;
    step("lw_x0", C_IDLE);
    LoadE = 1'b0; PCSrcE = 1'b1;
    step("branch", C_BR);
    LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    step("br_lw", C_BRLW);
    LoadE = 1'b0; PCSrcE = 1'b0; RdE = '0; Rs1D = '0;

    // Multi-cycle op; branch/load inputs ignored while busy.
    MulDivStartE = 1'b1;
    step("md_c0", C_MD0);
    PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
    step("md_c1", C_MDB);
    step("md_c2", C_MDB);
    step("md_c3", C_BUSY);
    MulDivStartE = 1'b0; PCSrcE = 1'b0; LoadE = 1'b0; RdE = '0; Rs1D = '0;
    step("md_c4", C_IDLE);

    // Memory wait beats a simultaneous multi-cycle op and branch.
    MemReqM = 1'b1; PCSrcE = 1'b1; MulDivStartE = 1'b1;
    step("mw_c0", C_MW0);
    for (int k = 1; k < 10; k++) step($sformatf("mw_c%0d", k), C_MWB);
    MemReadyM = 1'b1;
    step("mw_ready", C_BUSY);
    MemReqM = 1'b0; MemReadyM = 1'b0;
    step("mw_md0", C_MD0);
    PCSrcE = 1'b0;
    step("mw_md1", C_MDB);
    step("mw_md2", C_MDB);
    step("mw_md3", C_BUSY);
    MulDivStartE = 1'b0;
    step("mw_md4", C_IDLE);

    // Reset in the middle of a multi-cycle op.
    MulDivStartE = 1'b1;
    step("rs_c0", C_MD0);
    step("rs_c1", C_MDB);
    #1; chk("rs_c2", {22'b0, v}, {22'b0, C_MDB});
    #1; rst_n = 1'b0;
    #1; chk("rs_async", {22'b0, v}, {22'b0, C_IDLE});
    chk("rs_async8", {22'b0, v8}, {22'b0, C_IDLE});
    @(negedge clk); chk("rs_hold", {22'b0, v}, {22'b0, C_IDLE});
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("rs_md0", C_MD0);
    step("rs_md1", C_MDB);
    step("rs_md2", C_MDB);
    step("rs_md3", C_BUSY);
    MulDivStartE = 1'b0;
    step("rs_md4", C_IDLE);

    // Memory timeout on the short-timeout instance.
    MemReqM = 1'b1;
    step8("to_c0", C_MW0);
    for (int k = 1; k < 8; k++) step8($sformatf("to_c%0d", k), C_MWB);
    MemReqM = 1'b0;
    step8("to_c8", C_BUSY);
    @(negedge clk);
    chk("to_err", {22'b0, v8}, {22'b0, C_ERR});
    chk("to_long", {22'b0, v}, {22'b0, C_MWB});
    @(posedge clk); #1;
    MemReadyM = 1'b1;
    step8("to_c10", C_IDLE);
    MemReadyM = 1'b0;
    step("to_main_idle", C_IDLE);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
